// File: rtl/proc_imem_responder.sv
// -----------------------------------------------------------------------------
// proc_imem_responder
//   Instruction-memory responder for the processor fetch path. Holds a
//   2**ADDR_WIDTH entry program store (preloaded via the write port), reads it
//   when a fetch request is accepted, carries {addr, data} through a
//   LATENCY-1 stage pipeline and parks it in an in-order response queue.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_val    fetch request valid            (in)
//   req_rdy    fetch request can be accepted  (out)
//   req_addr   fetch address / pc             (in)
//   resp_val   response valid                 (out)
//   resp_rdy   initiator takes response       (in)
//   resp_addr  echoed fetch address           (out)
//   resp_data  instruction word               (out)
//   wr_en      program-store write enable     (in)
//   wr_addr    program-store write address    (in)
//   wr_data    program-store write data       (in)
// -----------------------------------------------------------------------------
module proc_imem_responder #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_val,
   output logic                  req_rdy,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  resp_val,
   input  logic                  resp_rdy,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic [DATA_WIDTH-1:0] resp_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   localparam int ENTRIES = 2 ** ADDR_WIDTH;
   localparam int STAGES  = LATENCY - 1;
   localparam int PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW      = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0] QD_C   = CW'(QUEUE_DEPTH);
   localparam logic [PW-1:0] PTR_MX = PW'(QUEUE_DEPTH - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } ent_t;

   // ---------------------------------------------------------------------------
   // Handshake and occupancy
   // ---------------------------------------------------------------------------
   logic          alive;      // 0 in reset, 1 from the first edge after release
   logic [CW-1:0] occ;        // in flight + queued
   logic          req_fire;
   logic          resp_fire;

   // req_rdy comes only from flops, so there is no combinational path from
   // resp_rdy or req_val. The occupancy count reserves a queue slot for every
   // pipeline entry, so an accepted request can always be enqueued.
   assign req_rdy   = alive & (occ < QD_C);
   assign req_fire  = req_val & req_rdy;
   assign resp_fire = resp_val & resp_rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive <= 1'b0;
         occ   <= '0;
      end else begin
         alive <= 1'b1;
         unique case ({req_fire, resp_fire})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Program store: read is combinational in the fire cycle, so a same-address
   // write in that cycle is only seen by the following read.
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [ENTRIES];
   ent_t                  rd_ent;

   assign rd_ent = '{addr: req_addr, data: mem[req_addr]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Read pipeline: LATENCY-1 register stages between the read and the queue.
   // ---------------------------------------------------------------------------
   logic enq_vld;
   ent_t enq_ent;

   generate
      if (STAGES == 0) begin : g_nopipe
         assign enq_vld = req_fire;
         assign enq_ent = rd_ent;
      end else begin : g_pipe
         logic [STAGES:1] vld_pipe;
         ent_t            ent_pipe [1:STAGES];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               vld_pipe <= '0;
               for (int s = 1; s <= STAGES; s++) ent_pipe[s] <= '0;
            end else begin
               vld_pipe[1] <= req_fire;
               ent_pipe[1] <= rd_ent;
               for (int s = 2; s <= STAGES; s++) begin
                  vld_pipe[s] <= vld_pipe[s-1];
                  ent_pipe[s] <= ent_pipe[s-1];
               end
            end
         end

         assign enq_vld = vld_pipe[STAGES];
         assign enq_ent = ent_pipe[STAGES];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Response queue. Full/empty come from the count; pointers wrap modulo
   // QUEUE_DEPTH so a non-power-of-two depth works too.
   // ---------------------------------------------------------------------------
   ent_t          q [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] qcnt;
   ent_t          head;

   assign head      = q[rd_ptr];
   assign resp_val  = (qcnt != '0);
   assign resp_addr = head.addr;
   assign resp_data = head.data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         qcnt   <= '0;
      end else begin
         if (enq_vld) begin
            q[wr_ptr] <= enq_ent;
            wr_ptr    <= (wr_ptr == PTR_MX) ? '0 : wr_ptr + 1'b1;
         end
         if (resp_fire) begin
            rd_ptr <= (rd_ptr == PTR_MX) ? '0 : rd_ptr + 1'b1;
         end
         unique case ({enq_vld, resp_fire})
            2'b10:   qcnt <= qcnt + 1'b1;
            2'b01:   qcnt <= qcnt - 1'b1;
            default: qcnt <= qcnt;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_proc_imem_responder
//   Scoreboard bench: every accepted fetch pushes {addr, model data} onto a
//   queue; every response handshake pops and compares in order.
// -----------------------------------------------------------------------------
module tb_proc_imem_responder;

   localparam int AW  = 4;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int QD  = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_val = 1'b0;
   logic          req_rdy;
   logic [AW-1:0] req_addr = '0;
   logic          resp_val;
   logic          resp_rdy = 1'b0;
   logic [AW-1:0] resp_addr;
   logic [DW-1:0] resp_data;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb [$];
   logic [DW-1:0] model_mem [2**AW];
   bit   rdy_mon_en = 1'b0;

   proc_imem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT), .QUEUE_DEPTH(QD)
   ) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr),
      .resp_val(resp_val), .resp_rdy(resp_rdy),
      .resp_addr(resp_addr), .resp_data(resp_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget = 200;
      while (sb.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   // Monitor on the falling edge: inputs and registered outputs are stable and
   // reflect exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
      end else begin
         if (rdy_mon_en) chk("req_rdy_occ", req_rdy, (sb.size() < QD));
         if (resp_val) begin
            if (sb.size() == 0) begin
               chk("stale_resp", resp_val, 1'b0);
            end else begin
               chk("resp_addr", resp_addr, sb[0].addr);
               chk("resp_data", resp_data, sb[0].data);
               if (resp_rdy) void'(sb.pop_front());
            end
         end
         // The read happens before a same-cycle write lands.
         if (req_val && req_rdy) sb.push_back('{addr: req_addr, data: model_mem[req_addr]});
         if (wr_en) model_mem[wr_addr] = wr_data;
      end
   end

   initial begin
      int idx;
      int budget;

      // Reset held for two cycles
      resp_rdy = 1'b1;
      tick(); tick();
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_resp_addr", resp_addr, 0);
      chk("rst_resp_data", resp_data, 0);
      reset = 1'b1;
      #1;
      chk("rel_req_rdy_pre_edge", req_rdy, 0);
      tick();
      chk("rel_req_rdy", req_rdy, 1);
      rdy_mon_en = 1'b1;

      // Fetch of an unwritten entry returns zero
      req_val = 1'b1; req_addr = 4'd5;
      tick();
      req_val = 1'b0;
      drain();

      // Preload mem[i] = 0x10 + i
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'h10 + i);
         tick();
      end
      wr_en = 1'b0;

      // Latency: accept in cycle T, resp_val first in T+2
      req_val = 1'b1; req_addr = 4'd3;
      tick();
      req_val = 1'b0;
      chk("lat_t1_val", resp_val, 0);
      tick();
      chk("lat_t2_val", resp_val, 1);
      chk("lat_t2_data", resp_data, 8'h13);
      drain();

      // Streaming 0..15 back-to-back
      for (int i = 0; i < 16; i++) begin
         req_val = 1'b1; req_addr = AW'(i);
         chk("stream_rdy", req_rdy, 1);
         if (i >= LAT) chk("stream_val", resp_val, 1);
         tick();
      end
      req_val = 1'b0;
      chk("stream_tail0", resp_val, 1);
      tick();
      chk("stream_tail1", resp_val, 1);
      drain();

      // Backpressure: 6 requests held until accepted, resp_rdy low
      resp_rdy = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         req_val = 1'b1; req_addr = AW'(idx);
         if (req_rdy) idx++;
         tick();
      end
      chk("bp_accepted", idx, 4);
      chk("bp_req_rdy", req_rdy, 0);
      chk("bp_resp_val", resp_val, 1);
      resp_rdy = 1'b1;
      budget = 50;
      while (idx < 6 && budget > 0) begin
         req_val = 1'b1; req_addr = AW'(idx);
         if (req_rdy) idx++;
         tick();
         budget--;
      end
      req_val = 1'b0;
      chk("bp_all_accepted", idx, 6);
      drain();

      // Write/read collision on addr 7
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hAA;
      req_val = 1'b1; req_addr = 4'd7;
      tick();
      wr_en = 1'b0;
      tick();
      req_val = 1'b0;
      drain();

      // Reset mid-operation with three queued responses
      resp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_val = 1'b1; req_addr = AW'(i);
         tick();
      end
      req_val = 1'b0;
      tick(); tick();
      chk("mid_resp_val_before", resp_val, 1);
      #2;
      rdy_mon_en = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_resp_val_async", resp_val, 0);
      chk("mid_req_rdy_async", req_rdy, 0);
      chk("mid_resp_data_async", resp_data, 0);
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("mid_req_rdy_after", req_rdy, 1);
      rdy_mon_en = 1'b1;
      resp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("mid_no_stale", resp_val, 0);
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         req_val = 1'b1; req_addr = AW'(i);
         tick();
      end
      req_val = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time guard
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/proc_imem_responder.md
Name: proc_imem_responder

Overview:
- Instruction-memory responder serving fetch requests from the processor (initiator) over a val/rdy request/response interface.
- 16-entry program store with a write port for bench/loader preload, a fixed-latency read pipeline and a response queue so backpressure on the response side never drops data.
- Sits between the processor's fetch side (pc -> instruction) and the program loader.

Parameters:
- ADDR_WIDTH, 4, address width; store holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, instruction word width.
- LATENCY, 2, cycles from request accept to earliest resp_val; legal 1..4.
- QUEUE_DEPTH, 4, maximum outstanding requests (in flight plus queued); must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_val  in  1  fetch request valid.
- req_rdy  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  fetch address (pc).
- resp_val  out  1  response valid.
- resp_rdy  in  1  initiator accepts response.
- resp_addr  out  ADDR_WIDTH  echo of the request address.
- resp_data  out  DATA_WIDTH  instruction word.
- wr_en  in  1  program-store write enable.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.

Behaviour:
- Reset (reset=0, asynchronous): all store entries = 0; pipeline valids, queue, pointers and occupancy cleared; req_rdy=0, resp_val=0, resp_addr=0, resp_data=0 while reset is low. First edge after release: req_rdy=1.
- A reset assertion mid-operation discards every in-flight and queued response; no response ever appears for a request accepted before reset.
- Request fire = req_val & req_rdy. Response fire = resp_val & resp_rdy.
- req_rdy = (occupancy < QUEUE_DEPTH). It is driven from registered occupancy only, with no combinational path from resp_rdy or req_val.
- Occupancy counter:
  - +1 on request fire, -1 on response fire.
  - Both in one cycle: unchanged.
  - Never exceeds QUEUE_DEPTH and never underflows.
- Read: the store is read in the fire cycle T (data visible at that edge). {addr, data} travels a LATENCY-1 stage shift pipeline, then enters the response queue (FIFO, QUEUE_DEPTH entries).
- With the queue empty and resp_rdy=1, resp_val rises in cycle T+LATENCY.
- Responses leave strictly in request order.
- Queue head drives resp_addr/resp_data. They hold stable while resp_val=1 and resp_rdy=0.
- Throughput: one response per cycle sustained when QUEUE_DEPTH >= LATENCY+1 and resp_rdy is held at 1. With defaults this is met: back-to-back fetches, no bubbles after the first LATENCY cycles.
- Backpressure: resp_rdy=0 lets the queue fill. req_rdy drops once occupancy = QUEUE_DEPTH; in-flight pipeline entries always have a queue slot reserved by the occupancy count.
- Write: wr_en=1 updates the entry at the rising edge; writes are always accepted and are independent of the handshake.
- Read/write same address, same cycle: the read returns the old data; the next cycle's read sees the new data.
- The queue pointers wrap modulo QUEUE_DEPTH; the full and empty conditions are derived from the count, not the pointer equality alone.
- Address wraps naturally: ADDR_WIDTH bits cover the whole store, so there is no out-of-range case.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> req_rdy=0 and resp_val=0. After release, fetch addr 5 -> resp_data=0x00, resp_addr=5.
- Preload and latency: write mem[i]=0x10+i for i=0..15; request addr 3 in cycle T with resp_rdy=1 -> resp_val=1 first in T+2, resp_data=0x13.
- Streaming: requests addr 0..15 back-to-back with resp_rdy=1 -> req_rdy never drops; responses 0x10..0x1F in consecutive cycles, in order.
- Backpressure: resp_rdy=0 and issue 6 requests (addr 0..5) -> exactly 4 accepted, req_rdy=0 after the 4th. Then resp_rdy=1 -> 0x10..0x13 in order; remaining requests are accepted as slots free.
- Write/read collision: mem[7]=0x17; in one cycle write 0xAA to addr 7 and fetch addr 7 -> response 0x17; the next fetch of addr 7 -> 0xAA.
- Reset mid-operation: 3 outstanding requests, resp_rdy=0, then assert reset=0 asynchronously between edges -> resp_val falls immediately and req_rdy=0. After release, occupancy=0, no stale responses appear, and all entries read 0x00.
